// File: rtl/channel_capture_ctrl_if.sv
// ----------------------------------------------------------------------------
// channel_capture_ctrl_if
// Bundles the acquisition controls, channel inputs and display-side outputs
// of channel_capture_ctrl. clk and rst_n stay outside as plain ports.
//   master : host/stimulus side (drives samples and controls, reads results)
//   slave  : the capture controller itself
// Signals:
//   sample_in     CHANNELS             channel inputs, synchronous to clk
//   trig_ch       $clog2(CHANNELS)+1   trigger channel index
//   trig_edge     1                    1 = rising, 0 = falling trigger
//   arm           1                    pulse, starts acquisition from IDLE
//   single        1                    1 = stop after publish, 0 = re-arm
//   abort         1                    level, forces IDLE
//   frame_start   1                    pulse at start of vertical blanking
//   capture_data  CHANNELS*DATA_SIZE   published display buffer
//   frame_updated 1                    pulse when capture_data changes
//   state         2                    0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
// ----------------------------------------------------------------------------
interface channel_capture_ctrl_if #(
    parameter int CHANNELS  = 4,
    parameter int DATA_SIZE = 256
);
    localparam int TW = $clog2(CHANNELS) + 1;

    logic [CHANNELS-1:0]           sample_in;
    logic [TW-1:0]                 trig_ch;
    logic                          trig_edge;
    logic                          arm;
    logic                          single;
    logic                          abort;
    logic                          frame_start;
    logic [CHANNELS*DATA_SIZE-1:0] capture_data;
    logic                          frame_updated;
    logic [1:0]                    state;

    modport master (
        output sample_in, trig_ch, trig_edge, arm, single, abort, frame_start,
        input  capture_data, frame_updated, state
    );

    modport slave (
        input  sample_in, trig_ch, trig_edge, arm, single, abort, frame_start,
        output capture_data, frame_updated, state
    );
endinterface

// File: rtl/channel_capture_ctrl.sv
// ----------------------------------------------------------------------------
// channel_capture_ctrl
// Acquisition sequencer for the multi-channel trace display. Samples the
// channel inputs at a programmable rate, waits for an edge on the selected
// trigger channel, captures DATA_SIZE samples per channel into a shadow
// buffer and publishes that buffer to the renderers only at frame_start so
// the displayed trace never tears mid-frame.
// Ports:
//   clk    in  system/pixel clock
//   rst_n  in  asynchronous active-low reset
//   bus    channel_capture_ctrl_if.slave (samples, controls, display outputs)
// ----------------------------------------------------------------------------
module channel_capture_ctrl #(
    parameter int CHANNELS   = 4,
    parameter int DATA_SIZE  = 256,
    parameter int SAMPLE_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    channel_capture_ctrl_if.slave bus
);
    localparam int TW = $clog2(CHANNELS) + 1;
    localparam int CW = $clog2(DATA_SIZE);
    localparam logic [15:0]   DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [15:0]                   div_cnt;
    logic                          tick;
    logic                          prev_trig;
    logic                          prev_valid;
    logic                          cur;
    logic                          ch_ok;
    logic                          fire;
    logic [CW-1:0]                 cnt;
    logic [CHANNELS*DATA_SIZE-1:0] shadow;
    logic [CHANNELS*DATA_SIZE-1:0] capture_q;
    logic                          updated_q;

    // FSM-issued strobes for the datapath
    logic shift_en;
    logic cnt_load;
    logic cnt_inc;
    logic publish;
    logic enter_armed;

    assign tick = (div_cnt == DIV_LAST);

    // Out-of-range trigger channel leaves ch_ok low, so the trigger can never fire.
    always_comb begin
        cur   = 1'b0;
        ch_ok = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (bus.trig_ch == TW'(c)) begin
                cur   = bus.sample_in[c];
                ch_ok = 1'b1;
            end
        end
    end

    // prev_valid suppresses a false edge against a stale prev_trig right after arming.
    assign fire = tick & prev_valid & ch_ok &
                  (bus.trig_edge ? (~prev_trig & cur) : (prev_trig & ~cur));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        shift_en    = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        publish     = 1'b0;
        enter_armed = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        state_d     = ARMED;
                        enter_armed = 1'b1;
                    end
                end
                ARMED: begin
                    if (fire) begin
                        shift_en = 1'b1;
                        cnt_load = 1'b1;
                        state_d  = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (tick) begin
                        shift_en = 1'b1;
                        if (cnt == CNT_LAST) state_d = DONE;
                        else                 cnt_inc = 1'b1;
                    end
                end
                DONE: begin
                    // Only a frame_start seen while already in DONE publishes.
                    if (bus.frame_start) begin
                        publish = 1'b1;
                        if (bus.single) begin
                            state_d = IDLE;
                        end else begin
                            state_d     = ARMED;
                            enter_armed = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            prev_trig  <= 1'b0;
            prev_valid <= 1'b0;
            cnt        <= '0;
            shadow     <= '0;
            capture_q  <= '0;
            updated_q  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 16'd1;

            if (tick) prev_trig <= cur;

            if (enter_armed)                     prev_valid <= 1'b0;
            else if (state_q == ARMED && tick)   prev_valid <= 1'b1;

            if (cnt_load)     cnt <= CW'(1);
            else if (cnt_inc) cnt <= cnt + CW'(1);

            // Newest sample enters at the top, so the trigger sample ends at bit 0.
            // After an abort the stale shadow is simply overwritten by the next capture.
            if (shift_en) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    shadow[c*DATA_SIZE +: DATA_SIZE] <=
                        {bus.sample_in[c], shadow[c*DATA_SIZE+1 +: DATA_SIZE-1]};
                end
            end

            updated_q <= publish;
            if (publish) capture_q <= shadow;
        end
    end

    assign bus.capture_data  = capture_q;
    assign bus.frame_updated = updated_q;
    assign bus.state         = state_q;

endmodule
